// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Four-way round-robin arbiter that feeds a single UART tx buffer. Once a
//   requester wins, it holds the grant (locked) until it sends a byte marked
//   last, or until it goes quiet for more than TIMEOUT cycles, in which case
//   the lock is dropped with a one-cycle abort pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req[i]     requester i has a byte pending
//   reqData    requester i's byte on [8i+7:8i]
//   reqLast[i] requester i's pending byte ends its packet
//   full       downstream tx buffer is full; no strobe is issued while high
//   ack[i]     one-cycle pulse when requester i's byte is taken
//   data       byte to the tx buffer (holds its value between strobes)
//   dataReady  one-cycle write strobe to the tx buffer
//   owner      index of the granted requester
//   locked     high while a packet holds the grant
//   abort      one-cycle pulse when a lock is dropped by timeout
module uart_tx_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] reqData,
  input  logic [3:0]  reqLast,
  input  logic        full,
  output logic [3:0]  ack,
  output logic [7:0]  data,
  output logic        dataReady,
  output logic [1:0]  owner,
  output logic        locked,
  output logic        abort
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t         stateReg, stateNext;
  logic [3:0]     ackReg, ackNext;
  logic [7:0]     dataReg, dataNext;
  logic           dataReadyReg, dataReadyNext;
  logic [1:0]     ownerReg, ownerNext;
  logic           lockedReg, lockedNext;
  logic           abortReg, abortNext;
  logic [CW-1:0]  toCntReg, toCntNext;
  logic           lastFlagReg, lastFlagNext;
  logic [1:0]     lastOwnerReg, lastOwnerNext;

  logic [7:0]     reqByte [4];
  logic           pickFound;
  logic [1:0]     pickIdx;
  logic           timedOut;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    assign reqByte[gi] = reqData[8*gi +: 8];
  end

  // Round-robin search starting one past the previous owner.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = lastOwnerReg;
    for (int k = 1; k <= 4; k++) begin
      if (!pickFound && req[lastOwnerReg + 2'(k)]) begin
        pickFound = 1'b1;
        pickIdx   = lastOwnerReg + 2'(k);
      end
    end
  end

  // A full buffer freezes GRANT entirely, so the timeout cannot fire then.
  assign timedOut = (stateReg == GRANT) && !full && (toCntReg == TO_MAX);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg     <= IDLE;
      ackReg       <= '0;
      dataReg      <= '0;
      dataReadyReg <= 1'b0;
      ownerReg     <= '0;
      lockedReg    <= 1'b0;
      abortReg     <= 1'b0;
      toCntReg     <= '0;
      lastFlagReg  <= 1'b0;
      lastOwnerReg <= 2'd3;
    end else begin
      stateReg     <= stateNext;
      ackReg       <= ackNext;
      dataReg      <= dataNext;
      dataReadyReg <= dataReadyNext;
      ownerReg     <= ownerNext;
      lockedReg    <= lockedNext;
      abortReg     <= abortNext;
      toCntReg     <= toCntNext;
      lastFlagReg  <= lastFlagNext;
      lastOwnerReg <= lastOwnerNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:  if (pickFound) stateNext = GRANT;
      GRANT: begin
        if (timedOut)                       stateNext = IDLE;
        else if (!full && req[ownerReg])    stateNext = HOLD;
      end
      HOLD:  stateNext = lastFlagReg ? IDLE : GRANT;
      default: stateNext = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    ackNext       = '0;
    dataReadyNext = 1'b0;
    abortNext     = 1'b0;
    dataNext      = dataReg;
    ownerNext     = ownerReg;
    lockedNext    = lockedReg;
    toCntNext     = toCntReg;
    lastFlagNext  = lastFlagReg;
    lastOwnerNext = lastOwnerReg;
    case (stateReg)
      IDLE: begin
        lockedNext = 1'b0;
        if (pickFound) begin
          ownerNext  = pickIdx;
          lockedNext = 1'b1;
          toCntNext  = '0;
        end
      end
      GRANT: begin
        if (timedOut) begin
          abortNext     = 1'b1;
          lastOwnerNext = ownerReg;
          lockedNext    = 1'b0;
        end else if (!full) begin
          if (req[ownerReg]) begin
            dataReadyNext     = 1'b1;
            ackNext[ownerReg] = 1'b1;
            dataNext          = reqByte[ownerReg];
            lastFlagNext      = reqLast[ownerReg];
            toCntNext         = '0;
          end else begin
            toCntNext = toCntReg + CW'(1);
          end
        end
      end
      HOLD: begin
        if (lastFlagReg) begin
          lastOwnerNext = ownerReg;
          lockedNext    = 1'b0;
        end else begin
          toCntNext = '0;
        end
      end
      default: ;
    endcase
  end

  assign ack       = ackReg;
  assign data      = dataReg;
  assign dataReady = dataReadyReg;
  assign owner     = ownerReg;
  assign locked    = lockedReg;
  assign abort     = abortReg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (TIMEOUT=4). Table-driven per-cycle vectors
// for single-byte, round-robin and multi-byte packets, plus hand-written
// sequences for backpressure, timeout and mid-packet reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] reqData;
  logic [3:0]  reqLast;
  logic        full;
  logic [3:0]  ack;
  logic [7:0]  data;
  logic        dataReady;
  logic [1:0]  owner;
  logic        locked;
  logic        abort;

  int nChecks = 0;
  int nPass   = 0;

  uart_tx_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .reqData(reqData), .reqLast(reqLast),
    .full(full), .ack(ack), .data(data), .dataReady(dataReady),
    .owner(owner), .locked(locked), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          doRst;
    logic [3:0]  rq;
    logic [31:0] rd;
    logic [3:0]  rl;
    logic        fl;
    logic [3:0]  eAck;
    logic        eDr;
    logic [7:0]  eData;
    logic [1:0]  eOwn;
    logic        eLock;
    logic        eAbort;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit doRst, logic [3:0] rq, logic [31:0] rd, logic [3:0] rl,
                              logic fl, logic [3:0] eAck, logic eDr, logic [7:0] eData,
                              logic [1:0] eOwn, logic eLock, logic eAbort);
    vec_t v;
    v.doRst = doRst; v.rq = rq; v.rd = rd; v.rl = rl; v.fl = fl;
    v.eAck = eAck; v.eDr = eDr; v.eData = eData; v.eOwn = eOwn;
    v.eLock = eLock; v.eAbort = eAbort;
    return v;
  endfunction

  // Compare {ack, dataReady, data, owner, locked, abort} against expectation.
  task automatic check(input string name, input logic [3:0] eAck, input logic eDr,
                       input logic [7:0] eData, input logic [1:0] eOwn,
                       input logic eLock, input logic eAbort);
    logic [16:0] act, exp;
    act = {ack, dataReady, data, owner, locked, abort};
    exp = {eAck, eDr, eData, eOwn, eLock, eAbort};
    nChecks++;
    if (act !== exp)
      $display("FAIL %s: got ack=%b dr=%b data=%h owner=%0d locked=%b abort=%b, want ack=%b dr=%b data=%h owner=%0d locked=%b abort=%b",
               name, ack, dataReady, data, owner, locked, abort,
               eAck, eDr, eData, eOwn, eLock, eAbort);
    else
      nPass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = '0; reqData = '0; reqLast = '0; full = 1'b0;
    #1;
    check("reset_state", 4'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; reqData = '0; reqLast = '0; full = 1'b0;

    // Single-byte packet from requester 0: dataReady two edges after req.
    vecs.push_back(mk(1, 4'b0001, 32'h00000041, 4'b0001, 0, 4'b0000, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 32'h00000041, 4'b0001, 0, 4'b0001, 1, 8'h41, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h41, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h41, 0, 0, 0));
    // All four requesters with back-to-back 1-byte packets: order 0,1,2,3,0.
    vecs.push_back(mk(1, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0001, 1, 8'h30, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h30, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h30, 1, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0010, 1, 8'h31, 1, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h31, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h31, 2, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0100, 1, 8'h32, 2, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h32, 2, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h32, 3, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b1000, 1, 8'h33, 3, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h33, 3, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0000, 0, 8'h33, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h33323130, 4'b1111, 0, 4'b0001, 1, 8'h30, 0, 1, 0));
    // Requester 2 sends 0x43,0x44,0x45 while requester 0 waits with req high.
    vecs.push_back(mk(1, 4'b0100, 32'h00430000, 4'b0000, 0, 4'b0000, 0, 8'h00, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0101, 32'h00430050, 4'b0001, 0, 4'b0100, 1, 8'h43, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0101, 32'h00440050, 4'b0001, 0, 4'b0000, 0, 8'h43, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0101, 32'h00440050, 4'b0001, 0, 4'b0100, 1, 8'h44, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0101, 32'h00450050, 4'b0101, 0, 4'b0000, 0, 8'h44, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0101, 32'h00450050, 4'b0101, 0, 4'b0100, 1, 8'h45, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 32'h00000050, 4'b0001, 0, 4'b0000, 0, 8'h45, 2, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 32'h00000050, 4'b0001, 0, 4'b0000, 0, 8'h45, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 32'h00000050, 4'b0001, 0, 4'b0001, 1, 8'h50, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h50, 0, 0, 0));

    foreach (vecs[i]) begin
      if (vecs[i].doRst) doReset();
      req = vecs[i].rq; reqData = vecs[i].rd; reqLast = vecs[i].rl; full = vecs[i].fl;
      step();
      check($sformatf("vec%0d", i), vecs[i].eAck, vecs[i].eDr, vecs[i].eData,
            vecs[i].eOwn, vecs[i].eLock, vecs[i].eAbort);
      $display("vec%0d req=%b ack=%b dr=%b data=%h owner=%0d locked=%b abort=%b",
               i, req, ack, dataReady, data, owner, locked, abort);
    end

    // Backpressure: full held 10 cycles in GRANT, no strobe and no abort.
    doReset();
    req = 4'b0010; reqData = 32'h00006100; reqLast = 4'b0010;
    step();
    check("full_grant", 4'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0);
    full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("full_wait%0d", c), 4'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0);
    end
    full = 1'b0;
    step();
    check("full_release", 4'b0010, 1'b1, 8'h61, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    check("full_done", 4'b0, 1'b0, 8'h61, 2'd1, 1'b0, 1'b0);
    $display("full sequence: strobe after full fell, data=%h", data);

    // Timeout: owner 0 drops req mid-packet, requester 2 waits.
    doReset();
    req = 4'b0001; reqData = 32'h00000071; reqLast = 4'b0000;
    step();
    step();
    check("to_first_byte", 4'b0001, 1'b1, 8'h71, 2'd0, 1'b1, 1'b0);
    req = 4'b0100; reqData = 32'h00000000;
    step();  // HOLD -> GRANT
    check("to_back_grant", 4'b0, 1'b0, 8'h71, 2'd0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("to_idle%0d", c), 4'b0, 1'b0, 8'h71, 2'd0, 1'b1, 1'b0);
    end
    step();
    check("to_abort", 4'b0, 1'b0, 8'h71, 2'd0, 1'b0, 1'b1);
    step();
    check("to_next_grant", 4'b0, 1'b0, 8'h71, 2'd2, 1'b1, 1'b0);
    $display("timeout sequence: abort seen, next owner=%0d", owner);

    // Reset in GRANT with requester 2 locked: outputs clear immediately.
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 4'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    req = 4'b0000;
    step();
    rst = 1'b0;
    step();
    check("rst_quiet", 4'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    req = 4'b0010; reqData = 32'h00008200; reqLast = 4'b0010;
    step();
    check("rst_regrant", 4'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0);
    step();
    check("rst_strobe", 4'b0010, 1'b1, 8'h82, 2'd1, 1'b1, 1'b0);
    $display("reset sequence: requester 1 granted, data=%h", data);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
